pbs_damage_datapath: RTL and testbench

//  Battle datapath driven by the turn-control FSM. Holds both Pokemon HP registers and responds to

---
 rtl/pbs_damage_datapath.sv | 141 ++++++++++++++
 tb/tb_pbs_damage_datapath.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pbs_damage_datapath.sv
// Battle damage datapath: holds both HP registers, computes move damage (with optional LFSR crits)
// and drains the target HP one unit per tick period, reporting busy/done back to turn control.
module pbs_damage_datapath #(
  parameter int          HP_W        = 4,
  parameter int          MAX_HP      = 15,
  parameter int          DRAIN_TICKS = 1,
  parameter int          CRIT_EN     = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_pm,
  input  logic [1:0]      p_move,
  input  logic            apply_damage,
  input  logic            active_trainer,
  input  logic            target,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic [1:0]      ai_move,
  output logic            busy,
  output logic            damage_done,
  output logic            p_fainted,
  output logic            ai_fainted
);

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;

  // A zero seed would lock the LFSR, so it is silently promoted to 1.
  localparam logic [7:0]      SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [HP_W-1:0] HP_INIT   = HP_W'(MAX_HP);
  localparam int              TICK_W    = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DRAIN_TICKS - 1);

  state_t            state;
  logic [7:0]        lfsr;
  logic [7:0]        lfsr_next;
  logic              req_q;
  logic              req;
  logic              trainer_q;
  logic              target_q;
  logic [3:0]        rem;
  logic [TICK_W-1:0] tick;
  logic [1:0]        move;
  logic              crit;
  logic [3:0]        power;
  logic [3:0]        dmg;
  logic [HP_W-1:0]   tgt_hp;

  assign req        = apply_damage & ~req_q;
  assign p_fainted  = (p_hp == '0);
  assign ai_fainted = (ai_hp == '0);

  always_comb begin
    lfsr_next = {1'b0, lfsr[7:1]};
    if (lfsr[0]) lfsr_next = lfsr_next ^ 8'hB8;
    move   = trainer_q ? lfsr[1:0] : p_move;
    crit   = (CRIT_EN != 0) && (lfsr[2:0] == 3'd0);
    power  = {2'b00, move} + 4'd1;
    dmg    = crit ? {power[2:0], 1'b0} : power;
    tgt_hp = target_q ? ai_hp : p_hp;
  end

  // LFSR and request edge detector run freely; load_pm does not disturb them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr  <= SEED;
      req_q <= 1'b0;
    end else begin
      lfsr  <= lfsr_next;
      req_q <= apply_damage;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      p_hp        <= HP_INIT;
      ai_hp       <= HP_INIT;
      ai_move     <= 2'd0;
      busy        <= 1'b0;
      damage_done <= 1'b0;
      trainer_q   <= 1'b0;
      target_q    <= 1'b0;
      rem         <= 4'd0;
      tick        <= '0;
    end else if (load_pm) begin
      state       <= IDLE;
      p_hp        <= HP_INIT;
      ai_hp       <= HP_INIT;
      busy        <= 1'b0;
      damage_done <= 1'b0;
      rem         <= 4'd0;
      tick        <= '0;
    end else begin
      case (state)
        IDLE: begin
          damage_done <= 1'b0;
          if (req) begin
            trainer_q <= active_trainer;
            target_q  <= target;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (trainer_q) ai_move <= move;
          rem   <= dmg;
          tick  <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            // A fainted target still costs one tick period before finishing.
            if (tgt_hp == '0) begin
              state       <= DONE;
              damage_done <= 1'b1;
            end else begin
              if (target_q) ai_hp <= ai_hp - HP_W'(1);
              else          p_hp  <= p_hp - HP_W'(1);
              rem <= rem - 4'd1;
              if (rem == 4'd1 || tgt_hp == HP_W'(1)) begin
                state       <= DONE;
                damage_done <= 1'b1;
              end
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        DONE: begin
          damage_done <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbs_damage_datapath.sv
// Randomized self-checking bench for pbs_damage_datapath against a transaction-level battle model.
module tb_pbs_damage_datapath;

  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_pm;
  logic [1:0] p_move;
  logic       apply_damage;
  logic       active_trainer;
  logic       target;
  logic [3:0] p_hp;
  logic [3:0] ai_hp;
  logic [1:0] ai_move;
  logic       busy;
  logic       damage_done;
  logic       p_fainted;
  logic       ai_fainted;

  int checks = 0;
  int errors = 0;
  int m_p_hp, m_ai_hp, m_ai_move, crit_count;
  logic [7:0] ref_lfsr;

  pbs_damage_datapath #(.HP_W(4), .MAX_HP(15), .DRAIN_TICKS(1), .CRIT_EN(1), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .load_pm(load_pm), .p_move(p_move),
    .apply_damage(apply_damage), .active_trainer(active_trainer), .target(target),
    .p_hp(p_hp), .ai_hp(ai_hp), .ai_move(ai_move), .busy(busy),
    .damage_done(damage_done), .p_fainted(p_fainted), .ai_fainted(ai_fainted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 8'hB8;
    return n;
  endfunction

  // Reference LFSR: the polynomial sequence as seen by the design each cycle.
  always @(posedge clk) begin
    if (!reset_n) ref_lfsr <= SEED;
    else          ref_lfsr <= lfsr_step(ref_lfsr);
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkHp(input string tag);
    checkOutput({tag, "_p_hp"}, int'(p_hp), m_p_hp);
    checkOutput({tag, "_ai_hp"}, int'(ai_hp), m_ai_hp);
    checkOutput({tag, "_p_faint"}, int'(p_fainted), int'(m_p_hp == 0));
    checkOutput({tag, "_ai_faint"}, int'(ai_fainted), int'(m_ai_hp == 0));
  endtask

  // One damage request: apply_damage high for 'hold' cycles starting at cycle N (driven at a negedge).
  task automatic applyStimulus(input string tag, input bit tr, input bit tg,
                               input logic [1:0] mv, input int hold);
    logic [7:0] calc_lfsr;
    int move, dmg, hp, k, done_at, pulses;
    apply_damage = 1'b1; active_trainer = tr; target = tg; p_move = mv;
    @(negedge clk);
    calc_lfsr = ref_lfsr;
    if (hold <= 1) apply_damage = 1'b0;
    checkOutput({tag, "_busy_calc"}, int'(busy), 1);
    move = tr ? int'(calc_lfsr[1:0]) : int'(mv);
    dmg  = (move + 1) * ((calc_lfsr[2:0] == 3'd0) ? 2 : 1);
    if (calc_lfsr[2:0] == 3'd0) crit_count++;
    hp = tg ? m_ai_hp : m_p_hp;
    k  = (hp == 0) ? 1 : ((dmg < hp) ? dmg : hp);
    hp = (dmg < hp) ? hp - dmg : 0;
    if (tg) m_ai_hp = hp; else m_p_hp = hp;
    if (tr) m_ai_move = move;
    done_at = -1;
    pulses  = 0;
    for (int i = 2; i <= 24; i++) begin
      @(negedge clk);
      if (i >= hold) apply_damage = 1'b0;
      if (damage_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
    end
    checkOutput({tag, "_done_cycle"}, done_at, 2 + k);
    checkOutput({tag, "_done_pulses"}, pulses, 1);
    checkOutput({tag, "_ai_move"}, int'(ai_move), m_ai_move);
    checkOutput({tag, "_busy_end"}, int'(busy), 0);
    checkHp(tag);
  endtask

  task automatic doLoad();
    load_pm = 1'b1;
    @(negedge clk);
    load_pm = 1'b0;
    m_p_hp = 15;
    m_ai_hp = 15;
    checkHp("load");
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0; load_pm = 1'b0; p_move = 2'd0;
    apply_damage = 1'b0; active_trainer = 1'b0; target = 1'b0;
    m_p_hp = 15; m_ai_hp = 15; m_ai_move = 0; crit_count = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset state");
    checkHp("reset");
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(damage_done), 0);
    checkOutput("reset_ai_move", int'(ai_move), 0);

    $display("[TB] single player attack and held request");
    applyStimulus("p_move3", 1'b0, 1'b1, 2'd3, 1);
    doLoad();
    applyStimulus("held", 1'b0, 1'b1, 2'd1, 10);

    $display("[TB] drain to faint and attack on fainted target");
    doLoad();
    for (int i = 0; i < 10 && m_ai_hp > 0; i++) applyStimulus("to_faint", 1'b0, 1'b1, 2'd3, 1);
    applyStimulus("on_fainted", 1'b0, 1'b1, 2'd3, 1);

    $display("[TB] load_pm mid-drain");
    doLoad();
    apply_damage = 1'b1; active_trainer = 1'b0; target = 1'b1; p_move = 2'd3;
    @(negedge clk); apply_damage = 1'b0;
    @(negedge clk);
    @(negedge clk); load_pm = 1'b1;
    @(negedge clk); load_pm = 1'b0;
    checkHp("mid_load");
    checkOutput("mid_load_busy", int'(busy), 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (damage_done === 1'b1) pulses++;
      @(negedge clk);
    end
    checkOutput("mid_load_no_done", pulses, 0);

    $display("[TB] reset mid-drain");
    applyStimulus("pre_rst", 1'b1, 1'b1, 2'd0, 1);
    apply_damage = 1'b1; active_trainer = 1'b0; target = 1'b0; p_move = 2'd3;
    @(negedge clk); apply_damage = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    m_p_hp = 15; m_ai_hp = 15; m_ai_move = 0;
    checkHp("mid_rst");
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_ai_move", int'(ai_move), 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (damage_done === 1'b1) pulses++;
    end
    checkOutput("mid_rst_no_done", pulses, 0);

    $display("[TB] random AI attacks on player");
    for (int i = 0; i < 200; i++) begin
      if (m_p_hp == 0 && $urandom_range(0, 3) == 0) doLoad();
      applyStimulus("ai_rand", 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom_range(1, 3));
    end
    checkOutput("crits_seen", int'(crit_count > 0), 1);

    $display("[TB] random mixed requests");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) doLoad();
      applyStimulus("mix_rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
